// File: rtl/snd_player_if.sv
// ---------------------------------------------------------------------------
// snd_player_if
// Bundles the request/status signals of the note player.
//   sndReq  : enqueue sndCode this cycle (master -> slave)
//   sndCode : 4-bit note code, 0 rest, 1..12 C4..B4, 13..15 rest
//   sndClr  : flush queue and abort the current note
//   sndRdy  : queue not full (slave -> master)
//   sndBsy  : player active or queue non-empty
//   sndOn   : amplifier enable, high while a tone plays
//   sndWav  : square-wave audio
//   sndCur  : code currently playing, 0 outside PLAY
// ---------------------------------------------------------------------------
interface snd_player_if;
  logic       sndReq;
  logic [3:0] sndCode;
  logic       sndClr;
  logic       sndRdy;
  logic       sndBsy;
  logic       sndOn;
  logic       sndWav;
  logic [3:0] sndCur;

  modport master (
    output sndReq, output sndCode, output sndClr,
    input  sndRdy, input  sndBsy,  input  sndOn,
    input  sndWav, input  sndCur
  );

  modport slave (
    input  sndReq, input  sndCode, input  sndClr,
    output sndRdy, output sndBsy,  output sndOn,
    output sndWav, output sndCur
  );
endinterface

// File: rtl/snd_player.sv
// ---------------------------------------------------------------------------
// snd_player
// Queued square-wave note player. Note codes are pushed into a small FIFO;
// an IDLE/LOAD/PLAY(/GAP) sequencer pops one code at a time, plays it for
// NOTE_CYCLES clocks and optionally inserts a silent gap of GAP_CYCLES.
//
// Ports
//   clk    : single clock
//   reset  : synchronous, active-high; beats sndClr and sndReq
//   snd    : snd_player_if.slave (sndReq/sndCode/sndClr in,
//            sndRdy/sndBsy/sndOn/sndWav/sndCur out)
//
// Build option
//   SND_GAP_EN : when defined, every note is followed by a GAP state of
//                GAP_CYCLES silent clocks (GAP_CYCLES must then be >= 1).
//                When undefined there is no GAP state and GAP_CYCLES is
//                ignored.
// ---------------------------------------------------------------------------
module snd_player #(
  parameter int NOTE_CYCLES = 2500000,
  parameter int GAP_CYCLES  = 250000,
  parameter int FIFO_DEPTH  = 8
) (
  input logic         clk,
  input logic         reset,
  snd_player_if.slave snd
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
`ifdef SND_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd3;
`endif

  // Half-period reload values for codes 1..12; everything else is a rest.
  function automatic logic [15:0] f_half(input logic [3:0] code);
    logic [15:0] v;
    case (code)
      4'd1:    v = 16'd47778;
      4'd2:    v = 16'd45097;
      4'd3:    v = 16'd42566;
      4'd4:    v = 16'd40177;
      4'd5:    v = 16'd37922;
      4'd6:    v = 16'd35793;
      4'd7:    v = 16'd33784;
      4'd8:    v = 16'd31888;
      4'd9:    v = 16'd30098;
      4'd10:   v = 16'd28409;
      4'd11:   v = 16'd26815;
      4'd12:   v = 16'd25310;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic logic f_is_tone(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd12);
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // ----------------------------------------------------------- sequencer
  logic [1:0]  r_state;
  logic [3:0]  r_cur;
  logic        r_wav;
  logic [15:0] r_half;
  logic [15:0] r_half_cnt;
  logic [31:0] r_dur_cnt;

  logic        w_rdy;
  logic        w_push;
  logic        w_pop;
  logic        w_queued;
  logic [3:0]  w_head;
  logic [15:0] w_head_half;
  logic        w_head_tone;
  logic        w_cur_tone;
  logic        w_in_play;

`ifndef SND_GAP_EN
  // The gap length has no meaning without the GAP state.
  logic w_unused_gap;
  assign w_unused_gap = (GAP_CYCLES != 0);
`endif

  // Ready comes from the registered count only, so a pop in the same cycle
  // cannot make room for a request made while the queue is full.
  assign w_rdy    = (r_count < DEPTH_C);
  assign w_push   = snd.sndReq && w_rdy && !snd.sndClr && !reset;
  assign w_pop    = (r_state == S_LOAD) && !snd.sndClr;
  assign w_queued = (r_count != '0);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_half = f_half(w_head);
  assign w_head_tone = f_is_tone(w_head);
  assign w_cur_tone  = f_is_tone(r_cur);
  assign w_in_play   = (r_state == S_PLAY);

  // Storage array without reset so it can map onto RAM; the head is read
  // into r_cur during LOAD, which acts as the registered read port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= snd.sndCode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || snd.sndClr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || snd.sndClr) begin
      r_state    <= S_IDLE;
      r_cur      <= 4'd0;
      r_wav      <= 1'b0;
      r_half     <= 16'd0;
      r_half_cnt <= 16'd0;
      r_dur_cnt  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_queued) begin
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Every note starts in phase: wave high for a tone, low for a rest.
          r_cur      <= w_head;
          r_half     <= w_head_half;
          r_half_cnt <= w_head_tone ? (w_head_half - 16'd1) : 16'd0;
          r_wav      <= w_head_tone;
          r_dur_cnt  <= 32'(NOTE_CYCLES - 1);
          r_state    <= S_PLAY;
        end

        S_PLAY: begin
          if (r_dur_cnt == 32'd0) begin
            r_wav <= 1'b0;
            r_cur <= 4'd0;
`ifdef SND_GAP_EN
            r_dur_cnt <= 32'(GAP_CYCLES - 1);
            r_state   <= S_GAP;
`else
            r_state <= w_queued ? S_LOAD : S_IDLE;
`endif
          end else begin
            r_dur_cnt <= r_dur_cnt - 32'd1;
            if (w_cur_tone) begin
              if (r_half_cnt == 16'd0) begin
                r_wav      <= ~r_wav;
                r_half_cnt <= r_half - 16'd1;
              end else begin
                r_half_cnt <= r_half_cnt - 16'd1;
              end
            end
          end
        end

`ifdef SND_GAP_EN
        S_GAP: begin
          if (r_dur_cnt == 32'd0) begin
            r_state <= w_queued ? S_LOAD : S_IDLE;
          end else begin
            r_dur_cnt <= r_dur_cnt - 32'd1;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are qualified by PLAY so nothing leaks during LOAD or GAP.
  assign snd.sndRdy = w_rdy;
  assign snd.sndBsy = (r_state != S_IDLE) || w_queued;
  assign snd.sndOn  = w_in_play && w_cur_tone;
  assign snd.sndWav = w_in_play && r_wav;
  assign snd.sndCur = w_in_play ? r_cur : 4'd0;

endmodule

// File: tb/tb_snd_player.sv
// ---------------------------------------------------------------------------
// tb_snd_player
// Drives two player instances: a short-note one for queueing, rest, clear
// and reset scenarios, and a long-note one where the square wave actually
// toggles. Expected outputs come from a timeline model: note k of a burst
// starts 2 + k*slot cycles after the first push, slot = note + gap + 1.
// ---------------------------------------------------------------------------
module tb_snd_player;

  localparam int S_NOTE = 400;
  localparam int S_GAPC = 30;
  localparam int L_NOTE = 29000;
  localparam int L_GAPC = 30;
`ifdef SND_GAP_EN
  localparam int GEN = 1;
`else
  localparam int GEN = 0;
`endif
  localparam int S_SLOT = S_NOTE + GEN * S_GAPC + 1;
  localparam int L_SLOT = L_NOTE + GEN * L_GAPC + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snd_player_if sif ();
  snd_player_if lif ();

  snd_player #(.NOTE_CYCLES(S_NOTE), .GAP_CYCLES(S_GAPC), .FIFO_DEPTH(8)) u_short (
    .clk(clk), .reset(reset), .snd(sif)
  );
  snd_player #(.NOTE_CYCLES(L_NOTE), .GAP_CYCLES(L_GAPC), .FIFO_DEPTH(8)) u_long (
    .clk(clk), .reset(reset), .snd(lif)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] m_codes [16];
  int         m_n;

  function automatic int half_of(input logic [3:0] c);
    case (c)
      4'd1: return 47778;  4'd2: return 45097;  4'd3: return 42566;
      4'd4: return 40177;  4'd5: return 37922;  4'd6: return 35793;
      4'd7: return 33784;  4'd8: return 31888;  4'd9: return 30098;
      4'd10: return 28409; 4'd11: return 26815; 4'd12: return 25310;
      default: return 0;
    endcase
  endfunction

  // Expected {bsy,on,wav,cur} t cycles after the first push of a burst of
  // m_n codes into an idle, empty player.
  function automatic logic [6:0] model_out(input int t, input int note, input int slot);
    logic [6:0] res;
    int u, k, r, h;
    logic [3:0] c;
    logic tone, wav;
    res = 7'b100_0000;
    if (t >= 2) begin
      u = t - 2;
      k = u / slot;
      r = u % slot;
      if (u >= m_n * slot - 1) begin
        res = 7'd0;
      end else if (k < m_n && r < note) begin
        c = m_codes[k];
        h = half_of(c);
        tone = (h != 0);
        wav = 1'b0;
        if (tone) wav = (((r / h) % 2) == 0);
        res = {1'b1, tone, wav, c};
      end
    end
    return res;
  endfunction

  task automatic idle_inputs();
    sif.sndReq = 1'b0; sif.sndCode = 4'd0; sif.sndClr = 1'b0;
    lif.sndReq = 1'b0; lif.sndCode = 4'd0; lif.sndClr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.sndReq = 1'b1; sif.sndClr = 1'b1; sif.sndCode = 4'd5;
    lif.sndReq = 1'b1; lif.sndClr = 1'b0; lif.sndCode = 4'd3;
    repeat (3) @(negedge clk);
    checks++; if (sif.sndRdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", sif.sndRdy); end
    checks++; if (sif.sndBsy !== 1'b0) begin errors++; $display("FAIL reset_bsy: got %b want 0", sif.sndBsy); end
    checks++; if (sif.sndOn !== 1'b0) begin errors++; $display("FAIL reset_on: got %b want 0", sif.sndOn); end
    checks++; if (sif.sndWav !== 1'b0) begin errors++; $display("FAIL reset_wav: got %b want 0", sif.sndWav); end
    checks++; if (sif.sndCur !== 4'd0) begin errors++; $display("FAIL reset_cur: got %0d want 0", sif.sndCur); end
    checks++;
    if ({lif.sndRdy, lif.sndBsy, lif.sndOn, lif.sndWav, lif.sndCur} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_long: got %b want 10000000",
               {lif.sndRdy, lif.sndBsy, lif.sndOn, lif.sndWav, lif.sndCur});
    end
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    // Requests presented during reset must not have been queued.
    checks++;
    if ({sif.sndBsy, lif.sndBsy} !== 2'b00) begin
      errors++; $display("FAIL reset_priority: bsy got %b want 00", {sif.sndBsy, lif.sndBsy});
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    logic [3:0] codes [2];
    logic [6:0] exp_v, obs_v, f_o, f_e;
    int bad, f_t;
    logic w1, w2;
    codes[0] = 4'd10;
    codes[1] = 4'($urandom_range(1, 12));
    for (int i = 0; i < 2; i++) begin
      do_reset();
      m_n = 1; m_codes[0] = codes[i];
      sif.sndReq = 1'b1; sif.sndCode = codes[i];
      bad = 0; f_t = 0; f_o = '0; f_e = '0; w1 = 1'bx; w2 = 1'bx;
      for (int t = 0; t < 2 + S_SLOT + 8; t++) begin
        @(negedge clk);
        sif.sndReq = 1'b0;
        if (t == 1) w1 = sif.sndWav;
        if (t == 2) w2 = sif.sndWav;
        exp_v = model_out(t, S_NOTE, S_SLOT);
        obs_v = {sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur};
        if (obs_v !== exp_v) begin
          if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
          bad++;
        end
      end
      checks++;
      if ({w1, w2} !== 2'b01) begin
        errors++; $display("FAIL single_latency: wav at N+1,N+2 got %b want 01", {w1, w2});
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_profile: code %0d, %0d cycles differ, first t=%0d got %b want %b",
                 codes[i], bad, f_t, f_o, f_e);
      end
      $display("test_single: code %0d played", codes[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] lists [2][8];
    logic [6:0] exp_v, obs_v, f_o, f_e;
    int bad, f_t, rdy_low;
    lists[0][0] = 4'd7; lists[0][1] = 4'd7; lists[0][2] = 4'd2; lists[0][3] = 4'd3;
    lists[0][4] = 4'd9; lists[0][5] = 4'd9; lists[0][6] = 4'd5; lists[0][7] = 4'd7;
    for (int j = 0; j < 8; j++) lists[1][j] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 2; i++) begin
      do_reset();
      m_n = 8;
      for (int j = 0; j < 8; j++) m_codes[j] = lists[i][j];
      sif.sndReq = 1'b1; sif.sndCode = lists[i][0];
      bad = 0; f_t = 0; f_o = '0; f_e = '0; rdy_low = 0;
      for (int t = 0; t < 2 + 8 * S_SLOT + 8; t++) begin
        @(negedge clk);
        if (t + 1 < 8) begin
          sif.sndReq = 1'b1; sif.sndCode = lists[i][t + 1];
          if (sif.sndRdy !== 1'b1) rdy_low++;
        end else begin
          sif.sndReq = 1'b0;
        end
        exp_v = model_out(t, S_NOTE, S_SLOT);
        obs_v = {sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur};
        if (obs_v !== exp_v) begin
          if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
          bad++;
        end
      end
      checks++;
      if (rdy_low != 0) begin
        errors++; $display("FAIL b2b_rdy: rdy low on %0d pushes, want 0", rdy_low);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL b2b_profile: list %0d, %0d cycles differ, first t=%0d got %b want %b",
                 i, bad, f_t, f_o, f_e);
      end
      $display("test_back_to_back: list %0d = %0d %0d %0d %0d %0d %0d %0d %0d", i,
               lists[i][0], lists[i][1], lists[i][2], lists[i][3],
               lists[i][4], lists[i][5], lists[i][6], lists[i][7]);
    end
  endtask

  task automatic test_rest();
    logic [6:0] exp_v, obs_v, f_o, f_e;
    int bad, f_t, loud;
    do_reset();
    m_n = 2; m_codes[0] = 4'd0; m_codes[1] = 4'd14;
    sif.sndReq = 1'b1; sif.sndCode = 4'd0;
    bad = 0; f_t = 0; f_o = '0; f_e = '0; loud = 0;
    for (int t = 0; t < 2 + 2 * S_SLOT + 8; t++) begin
      @(negedge clk);
      if (t == 0) begin sif.sndReq = 1'b1; sif.sndCode = 4'd14; end
      else sif.sndReq = 1'b0;
      if (sif.sndOn !== 1'b0 || sif.sndWav !== 1'b0) loud++;
      exp_v = model_out(t, S_NOTE, S_SLOT);
      obs_v = {sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur};
      if (obs_v !== exp_v) begin
        if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
        bad++;
      end
    end
    checks++;
    if (loud != 0) begin errors++; $display("FAIL rest_silent: %0d loud cycles, want 0", loud); end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rest_profile: %0d cycles differ, first t=%0d got %b want %b", bad, f_t, f_o, f_e);
    end
    $display("test_rest: codes 0 and 14 played");
  endtask

  task automatic test_full();
    logic [6:0] exp_v, obs_v, f_o, f_e;
    int bad, f_t, ready_t;
    logic z_done, rdy_full;
    do_reset();
    m_n = 10;
    m_codes[0] = 4'd1;
    for (int j = 1; j <= 8; j++) m_codes[j] = 4'($urandom_range(1, 12));
    m_codes[9] = 4'd5;
    sif.sndReq = 1'b1; sif.sndCode = m_codes[0];
    bad = 0; f_t = 0; f_o = '0; f_e = '0; ready_t = -1; z_done = 1'b0; rdy_full = 1'bx;
    for (int t = 0; t < 2 + 10 * S_SLOT + 8; t++) begin
      @(negedge clk);
      sif.sndReq = 1'b0;
      if (t >= 2 && t <= 9) begin
        sif.sndReq = 1'b1; sif.sndCode = m_codes[t - 1];
      end else if (t >= 10 && !z_done) begin
        if (t == 10) rdy_full = sif.sndRdy;
        if (sif.sndRdy === 1'b1) begin
          sif.sndReq = 1'b1; sif.sndCode = m_codes[9]; z_done = 1'b1; ready_t = t;
        end else begin
          // Held through the pop edge; must be dropped every time.
          sif.sndReq = 1'b1; sif.sndCode = 4'd13;
        end
      end
      exp_v = model_out(t, S_NOTE, S_SLOT);
      obs_v = {sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur};
      if (obs_v !== exp_v) begin
        if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
        bad++;
      end
    end
    checks++;
    if (rdy_full !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b want 0", rdy_full); end
    checks++;
    if (ready_t != 2 + S_SLOT) begin
      errors++; $display("FAIL full_ready_return: t=%0d want %0d", ready_t, 2 + S_SLOT);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_profile: %0d cycles differ, first t=%0d got %b want %b", bad, f_t, f_o, f_e);
    end
    $display("test_full: 8 queued behind first note, 9th accepted at t=%0d", ready_t);
  endtask

  task automatic test_clear();
    logic [6:0] exp_v, obs_v, f_o, f_e;
    int bad, f_t, busy;
    do_reset();
    m_n = 5;
    for (int j = 0; j < 5; j++) m_codes[j] = 4'($urandom_range(1, 12));
    sif.sndReq = 1'b1; sif.sndCode = m_codes[0];
    bad = 0; f_t = 0; f_o = '0; f_e = '0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (t < 4) begin sif.sndReq = 1'b1; sif.sndCode = m_codes[t + 1]; end
      else sif.sndReq = 1'b0;
      exp_v = model_out(t, S_NOTE, S_SLOT);
      obs_v = {sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur};
      if (obs_v !== exp_v) begin
        if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_pre: %0d cycles differ, first t=%0d got %b want %b", bad, f_t, f_o, f_e);
    end
    sif.sndClr = 1'b1; sif.sndReq = 1'b1; sif.sndCode = 4'd9;
    @(negedge clk);
    sif.sndClr = 1'b0; sif.sndReq = 1'b0;
    checks++;
    if ({sif.sndRdy, sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL clear_next_edge: rdy/bsy/on/wav/cur got %b want 10000000",
               {sif.sndRdy, sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur});
    end
    busy = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (sif.sndBsy !== 1'b0 || sif.sndWav !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL clear_stays_idle: %0d busy cycles, want 0", busy); end
    // A fresh note after the flush must come from the new push alone.
    m_n = 1; m_codes[0] = 4'd6;
    sif.sndReq = 1'b1; sif.sndCode = 4'd6;
    bad = 0; f_t = 0; f_o = '0; f_e = '0;
    for (int t = 0; t < 2 + S_SLOT + 8; t++) begin
      @(negedge clk);
      sif.sndReq = 1'b0;
      exp_v = model_out(t, S_NOTE, S_SLOT);
      obs_v = {sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur};
      if (obs_v !== exp_v) begin
        if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_after: %0d cycles differ, first t=%0d got %b want %b", bad, f_t, f_o, f_e);
    end
    $display("test_clear: flushed 4 queued codes, replayed code 6");
  endtask

  task automatic test_reset_midnote();
    int busy;
    do_reset();
    sif.sndReq = 1'b1; sif.sndCode = 4'd4;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (t < 2) begin sif.sndReq = 1'b1; sif.sndCode = 4'(t + 8); end
      else sif.sndReq = 1'b0;
    end
    checks++;
    if (sif.sndOn !== 1'b1) begin errors++; $display("FAIL midreset_playing: on got %b want 1", sif.sndOn); end
    reset = 1'b1; sif.sndReq = 1'b1; sif.sndClr = 1'b1; sif.sndCode = 4'd2;
    @(negedge clk);
    checks++;
    if ({sif.sndRdy, sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL midreset_edge: rdy/bsy/on/wav/cur got %b want 10000000",
               {sif.sndRdy, sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur});
    end
    reset = 1'b0; sif.sndReq = 1'b0; sif.sndClr = 1'b0;
    busy = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if ({sif.sndBsy, sif.sndOn, sif.sndWav, sif.sndCur} !== 7'd0) busy++;
    end
    checks++;
    if (busy != 0) begin errors++; $display("FAIL midreset_residual: %0d active cycles, want 0", busy); end
    $display("test_reset_midnote: note aborted");
  endtask

  task automatic test_tone_period();
    logic [6:0] exp_v, obs_v, f_o, f_e;
    int bad, f_t, fall_t;
    logic prev_wav;
    do_reset();
    m_n = 2; m_codes[0] = 4'd12; m_codes[1] = 4'd10;
    lif.sndReq = 1'b1; lif.sndCode = 4'd12;
    bad = 0; f_t = 0; f_o = '0; f_e = '0; fall_t = -1; prev_wav = 1'b0;
    for (int t = 0; t < 2 + 2 * L_SLOT + 5; t++) begin
      @(negedge clk);
      if (t == 0) begin lif.sndReq = 1'b1; lif.sndCode = 4'd10; end
      else lif.sndReq = 1'b0;
      if (fall_t < 0 && prev_wav === 1'b1 && lif.sndWav === 1'b0) fall_t = t;
      prev_wav = lif.sndWav;
      exp_v = model_out(t, L_NOTE, L_SLOT);
      obs_v = {lif.sndBsy, lif.sndOn, lif.sndWav, lif.sndCur};
      if (obs_v !== exp_v) begin
        if (bad == 0) begin f_t = t; f_o = obs_v; f_e = exp_v; end
        bad++;
      end
    end
    checks++;
    if (fall_t != 2 + 25310) begin
      errors++; $display("FAIL tone_first_toggle: t=%0d want %0d", fall_t, 2 + 25310);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tone_profile: %0d cycles differ, first t=%0d got %b want %b", bad, f_t, f_o, f_e);
    end
    $display("test_tone_period: codes 12 and 10 played");
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_rest();
    test_full();
    test_clear();
    test_reset_midnote();
    test_tone_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snd_player.md
SND_PLAYER -- requirements
Module: snd_player

Interface
REQ-001 Parameter NOTE_CYCLES, default 2500000: duration of one note in clk cycles (100 ms at 25 MHz).
REQ-002 Parameter GAP_CYCLES, default 250000: silent gap after each note in clk cycles (10 ms at 25 MHz).
REQ-003 Parameter FIFO_DEPTH, default 8: number of queued note codes (power of two, 2..16).
REQ-004 clk  input  1  single clock, 25 MHz pixel clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sndReq  input  1  request to enqueue sndCode this cycle.
REQ-007 sndCode  input  4  note code: 0 rest, 1..12 notes C4..B4, 13..15 rest.
REQ-008 sndClr  input  1  flush queue and abort current note.
REQ-009 sndRdy  output  1  queue not full; a request is accepted only when high.
REQ-010 sndBsy  output  1  high when state is not IDLE or queue is non-empty.
REQ-011 sndOn  output  1  amplifier enable; high only while a tone code (1..12) is in PLAY.
REQ-012 sndWav  output  1  square-wave audio output.
REQ-013 sndCur  output  4  code currently playing; 0 when not in PLAY.

Function
REQ-014 The block SHALL accept a request on a rising edge where sndReq=1, sndRdy=1 and sndClr=0.
REQ-015 sndRdy SHALL equal (count < FIFO_DEPTH), computed combinationally from the registered count.
REQ-016 A request while full SHALL be dropped, even if a pop occurs in the same cycle; the count SHALL NOT change.
REQ-017 A push and a pop in the same cycle on a non-full queue SHALL leave the count unchanged and preserve FIFO order.
REQ-018 The FSM SHALL have the states IDLE, LOAD, PLAY and GAP.
REQ-019 IDLE with a non-empty queue SHALL go to LOAD on the next edge; with an empty queue it SHALL stay in IDLE.
REQ-020 LOAD (one cycle) SHALL pop the head, latch it into sndCur, and load the half-period and duration counters; the next state is PLAY.
REQ-021 Half-period counts for codes 1..12 SHALL be 47778, 45097, 42566, 40177, 37922, 35793, 33784, 31888, 30098, 28409, 26815, 25310 (16-bit).
REQ-022 On PLAY entry for a tone code, sndWav SHALL be 1; it SHALL then toggle every half-period cycles.
REQ-023 For a rest code, sndWav and sndOn SHALL be held at 0 for the full note duration.
REQ-024 PLAY SHALL last exactly NOTE_CYCLES cycles and then go to GAP.
REQ-025 In GAP, sndWav=0, sndOn=0 and sndCur=0 for GAP_CYCLES cycles; the next state is LOAD if the queue is non-empty, else IDLE.
REQ-026 Latency: a request accepted into an empty queue at edge N in IDLE SHALL put the FSM in PLAY, with sndWav=1, from edge N+2.
REQ-027 sndClr=1 SHALL empty the queue, force IDLE, and zero sndWav, sndOn and sndCur on the next edge; a simultaneous sndReq is dropped.
REQ-028 Repeated identical codes SHALL play as separate notes, delimited by the gap.

Reset
REQ-029 While reset=1 at an edge: state IDLE, count 0, read/write pointers 0, all counters 0.
REQ-030 Output values during reset: sndRdy=1, sndBsy=0, sndOn=0, sndWav=0, sndCur=0.
REQ-031 Reset asserted mid-note SHALL abort the note and discard the queue with no residual toggle.
REQ-032 Reset SHALL take priority over sndClr and sndReq.

Configuration
REQ-033 Macro SND_GAP_EN defined: the GAP state and GAP_CYCLES behave as specified above.
REQ-034 Macro SND_GAP_EN undefined: there is no GAP state; PLAY end goes directly to LOAD (queue non-empty) or IDLE, and GAP_CYCLES is ignored.

Verification (NOTE_CYCLES=200000, GAP_CYCLES=1000 unless stated)
REQ-035 Push code 10 from idle -> sndWav=1 at edge N+2, period 56818 cycles, sndOn high for 200000 cycles, then a 1000-cycle gap, then IDLE with sndBsy=0.
REQ-036 Push 7,7,2,3,9,9,5,7 back-to-back -> all accepted, played in order, sndCur sequence matches, each note separated by a 1000-cycle silence.
REQ-037 Push 9 codes while the first note plays -> the 9th is accepted only after the first pop; with 10 pushes and no pop, the 10th is dropped and sndRdy=0.
REQ-038 Push code 0 and then code 14 -> sndOn=0 and sndWav=0 for 2x(200000+1000) cycles, sndCur shows 0 then 14.
REQ-039 Assert sndClr with sndReq mid-note, 4 codes queued -> next edge IDLE, count 0, sndWav=0, new code not stored.
REQ-040 Build without SND_GAP_EN, push 3,3 -> second note's PLAY starts 1 cycle (LOAD) after the first ends, sndWav re-phased to 1.
